// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned WaitW = 8;

  typedef enum logic {
    IDLE      = 1'b0,
    INS_BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INS  = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } resp_entry_t;

endpackage

// File: rtl/mem_port_arbiter_rd_resp_pipe.sv
// Fixed-depth shift register tracking which requester owns each read in flight.
module rd_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned ReadLatency = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  resp_entry_t entry_in,
  output resp_entry_t entry_out
);

  resp_entry_t stage [ReadLatency];

  // Shift one stage per cycle; reset discards every in-flight response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ReadLatency; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= entry_in;
      for (int unsigned i = 1; i < ReadLatency; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign entry_out = stage[ReadLatency-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: locked instruction refill bursts with a starvation
// escape for the load/store unit, and owner-steered read responses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned dataW       = 32,
  parameter int unsigned RAMAddrSize = 16,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned MaxWait     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ins_req,
  input  logic [RAMAddrSize-1:0] ins_addr,
  input  logic                   ins_last,
  output logic                   ins_gnt,
  output logic                   ins_rvalid,
  input  logic                   data_req,
  input  logic                   data_we,
  input  logic [RAMAddrSize-1:0] data_addr,
  input  logic [dataW-1:0]       data_wdata,
  input  logic [dataW/8-1:0]     data_be,
  output logic                   data_gnt,
  output logic                   data_rvalid,
  output logic [dataW-1:0]       rdata,
  output logic [RAMAddrSize-1:0] ram_addr,
  output logic                   ram_we,
  output logic [dataW/8-1:0]     ram_be,
  output logic [dataW-1:0]       ram_wdata,
  input  logic [dataW-1:0]       ram_rdata
);

  localparam int unsigned BeW = dataW / 8;

  arb_state_t       state;
  logic [WaitW-1:0] wait_cnt;
  logic             starved;
  resp_entry_t      resp_in;
  resp_entry_t      resp_out;

  assign starved = (wait_cnt >= WaitW'(MaxWait));

  // Grant decode: data wins in IDLE; inside a burst only on a bubble or starvation.
  always_comb begin
    ins_gnt  = 1'b0;
    data_gnt = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (data_req)     data_gnt = 1'b1;
          else if (ins_req) ins_gnt  = 1'b1;
        end
        INS_BURST: begin
          if (data_req && (starved || !ins_req)) data_gnt = 1'b1;
          else if (ins_req)                      ins_gnt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM port mux; idle port is driven to all zeros.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_wdata = '0;
    if (data_gnt) begin
      ram_addr  = data_addr;
      ram_we    = data_we;
      ram_be    = data_be;
      ram_wdata = data_wdata;
    end else if (ins_gnt) begin
      ram_addr  = ins_addr;
    end
  end

  // Response entry for this cycle's grant; stores and idle cycles push an empty slot.
  always_comb begin
    resp_in = '0;
    if (ins_gnt) begin
      resp_in.valid = 1'b1;
      resp_in.owner = OWN_INS;
    end else if (data_gnt && !data_we) begin
      resp_in.valid = 1'b1;
      resp_in.owner = OWN_DATA;
    end
  end

  // Burst lock state and data starvation counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE:      if (ins_gnt && !ins_last) state <= INS_BURST;
        INS_BURST: if (ins_gnt && ins_last)  state <= IDLE;
        default:   state <= IDLE;
      endcase
      if (data_gnt) begin
        wait_cnt <= '0;
      end else if (data_req && (wait_cnt != {WaitW{1'b1}})) begin
        wait_cnt <= wait_cnt + WaitW'(1);
      end
    end
  end

  rd_resp_pipe #(
    .ReadLatency (ReadLatency)
  ) u_rd_resp_pipe (
    .clock     (clock),
    .reset     (reset),
    .entry_in  (resp_in),
    .entry_out (resp_out)
  );

  assign ins_rvalid  = resp_out.valid && (resp_out.owner == OWN_INS);
  assign data_rvalid = resp_out.valid && (resp_out.owner == OWN_DATA);
  assign rdata       = reset ? '0 : ram_rdata;

  logic unused_be;
  assign unused_be = ^BeW;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at ReadLatency=1 (a_*)
// and one at ReadLatency=3 (b_*) driven with the same request stimulus.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ins_req, ins_last, data_req, data_we;
  logic [15:0] ins_addr, data_addr;
  logic [31:0] data_wdata, ram_rdata;
  logic [3:0]  data_be;

  logic        a_ins_gnt, a_ins_rvalid, a_data_gnt, a_data_rvalid, a_ram_we;
  logic [31:0] a_rdata, a_ram_wdata;
  logic [15:0] a_ram_addr;
  logic [3:0]  a_ram_be;
  logic        b_ins_gnt, b_ins_rvalid, b_data_gnt, b_data_rvalid, b_ram_we;
  logic [31:0] b_rdata, b_ram_wdata;
  logic [15:0] b_ram_addr;
  logic [3:0]  b_ram_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.dataW(32), .RAMAddrSize(16), .ReadLatency(1), .MaxWait(8)) u_lat1 (
    .clock(clock), .reset(reset),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_last(ins_last),
    .ins_gnt(a_ins_gnt), .ins_rvalid(a_ins_rvalid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be),
    .data_gnt(a_data_gnt), .data_rvalid(a_data_rvalid), .rdata(a_rdata),
    .ram_addr(a_ram_addr), .ram_we(a_ram_we), .ram_be(a_ram_be),
    .ram_wdata(a_ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.dataW(32), .RAMAddrSize(16), .ReadLatency(3), .MaxWait(8)) u_lat3 (
    .clock(clock), .reset(reset),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_last(ins_last),
    .ins_gnt(b_ins_gnt), .ins_rvalid(b_ins_rvalid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be),
    .data_gnt(b_data_gnt), .data_rvalid(b_data_rvalid), .rdata(b_rdata),
    .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_be(b_ram_be),
    .ram_wdata(b_ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet(input int n);
    ins_req = 1'b0; ins_last = 1'b0; ins_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ins_req = 1'b1; ins_last = 1'b0; ins_addr = 16'h1234;
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h5678;
    data_wdata = 32'hCAFEF00D; data_be = 4'hF; ram_rdata = 32'hA5A5A5A5;
    tick(); tick();
    vectors++; if (a_ins_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_ins_gnt got %b want 0", a_ins_gnt); end
    vectors++; if (a_data_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_data_gnt got %b want 0", a_data_gnt); end
    vectors++; if ({a_ram_addr, a_ram_we, a_ram_be, a_ram_wdata} !== '0) begin miscompares++; $display("FAIL reset_ram_port got %h/%b/%h/%h want 0", a_ram_addr, a_ram_we, a_ram_be, a_ram_wdata); end
    vectors++; if ({a_ins_rvalid, a_data_rvalid, a_rdata} !== '0) begin miscompares++; $display("FAIL reset_resp got %b/%b/%h want 0", a_ins_rvalid, a_data_rvalid, a_rdata); end
    quiet(0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_beat;
    ram_rdata = 32'h12345678;
    ins_req = 1'b1; ins_last = 1'b1; ins_addr = 16'h0040;
    #1;
    vectors++; if (a_ins_gnt !== 1'b1 || a_data_gnt !== 1'b0) begin miscompares++; $display("FAIL single_gnt got ins=%b data=%b want 1/0", a_ins_gnt, a_data_gnt); end
    vectors++; if (a_ram_addr !== 16'h0040 || a_ram_we !== 1'b0 || a_ram_be !== 4'h0) begin miscompares++; $display("FAIL single_ram got %h/%b/%h want 0040/0/0", a_ram_addr, a_ram_we, a_ram_be); end
    tick();
    ins_req = 1'b0; ins_last = 1'b0;
    #1;
    vectors++; if (a_ins_rvalid !== 1'b1 || a_data_rvalid !== 1'b0) begin miscompares++; $display("FAIL single_rvalid got ins=%b data=%b want 1/0", a_ins_rvalid, a_data_rvalid); end
    vectors++; if (a_rdata !== 32'h12345678) begin miscompares++; $display("FAIL single_rdata got %h want 12345678", a_rdata); end
    tick();
  endtask

  // Also proves the single-beat refill left the arbiter in IDLE: data wins the tie.
  task automatic test_collision;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0100;
    ins_req = 1'b1; ins_last = 1'b1; ins_addr = 16'h0000;
    #1;
    vectors++; if (a_data_gnt !== 1'b1 || a_ins_gnt !== 1'b0) begin miscompares++; $display("FAIL coll_first got data=%b ins=%b want 1/0", a_data_gnt, a_ins_gnt); end
    vectors++; if (a_ram_addr !== 16'h0100 || a_ram_we !== 1'b0) begin miscompares++; $display("FAIL coll_first_ram got %h/%b want 0100/0", a_ram_addr, a_ram_we); end
    tick();
    data_req = 1'b0;
    #1;
    vectors++; if (a_ins_gnt !== 1'b1 || a_data_gnt !== 1'b0) begin miscompares++; $display("FAIL coll_second got ins=%b data=%b want 1/0", a_ins_gnt, a_data_gnt); end
    vectors++; if (a_data_rvalid !== 1'b1 || a_ins_rvalid !== 1'b0) begin miscompares++; $display("FAIL coll_resp1 got data=%b ins=%b want 1/0", a_data_rvalid, a_ins_rvalid); end
    tick();
    ins_req = 1'b0; ins_last = 1'b0;
    #1;
    vectors++; if (a_ins_rvalid !== 1'b1 || a_data_rvalid !== 1'b0) begin miscompares++; $display("FAIL coll_resp2 got ins=%b data=%b want 1/0", a_ins_rvalid, a_data_rvalid); end
    quiet(2);
  endtask

  // 32-beat burst; load raised at cycle 2 waits 8 cycles and wins at cycle 10.
  task automatic test_starvation;
    int beat;
    logic exp_i, exp_d, prev_i, prev_d;
    logic [15:0] exp_addr;
    beat = 0; prev_i = 1'b0; prev_d = 1'b0;
    for (int c = 0; c < 33; c++) begin
      ins_req = (beat < 32); ins_addr = 16'h1000 + 16'(beat); ins_last = (beat == 31);
      data_req = (c >= 2 && c <= 10); data_we = 1'b0; data_addr = 16'h0300;
      exp_d = (c == 10); exp_i = !exp_d;
      exp_addr = exp_d ? 16'h0300 : 16'h1000 + 16'(beat);
      #1;
      vectors++; if (a_ins_gnt !== exp_i || a_data_gnt !== exp_d) begin miscompares++; $display("FAIL starve_gnt c=%0d got ins=%b data=%b want %b/%b", c, a_ins_gnt, a_data_gnt, exp_i, exp_d); end
      vectors++; if (a_ram_addr !== exp_addr) begin miscompares++; $display("FAIL starve_addr c=%0d got %h want %h", c, a_ram_addr, exp_addr); end
      vectors++; if (a_ins_rvalid !== prev_i || a_data_rvalid !== prev_d) begin miscompares++; $display("FAIL starve_rvalid c=%0d got ins=%b data=%b want %b/%b", c, a_ins_rvalid, a_data_rvalid, prev_i, prev_d); end
      prev_i = exp_i; prev_d = exp_d;
      if (exp_i) beat++;
      tick();
    end
    vectors++; if (beat !== 32) begin miscompares++; $display("FAIL starve_beats got %0d want 32", beat); end
    ins_req = 1'b1; ins_last = 1'b1; ins_addr = 16'h2000;
    data_req = 1'b1; data_addr = 16'h0304;
    #1;
    vectors++; if (a_ins_rvalid !== 1'b1) begin miscompares++; $display("FAIL starve_last_rvalid got %b want 1", a_ins_rvalid); end
    vectors++; if (a_data_gnt !== 1'b1 || a_ins_gnt !== 1'b0) begin miscompares++; $display("FAIL starve_idle_probe got data=%b ins=%b want 1/0", a_data_gnt, a_ins_gnt); end
    quiet(3);
  endtask

  task automatic test_bubble;
    ins_req = 1'b1; ins_last = 1'b0; ins_addr = 16'h0400;
    #1;
    vectors++; if (a_ins_gnt !== 1'b1) begin miscompares++; $display("FAIL bubble_beat0 got %b want 1", a_ins_gnt); end
    tick();
    ins_req = 1'b0;
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0200; data_be = 4'hF; data_wdata = 32'hDEADBEEF;
    #1;
    vectors++; if (a_data_gnt !== 1'b1 || a_ins_gnt !== 1'b0) begin miscompares++; $display("FAIL bubble_gnt got data=%b ins=%b want 1/0", a_data_gnt, a_ins_gnt); end
    vectors++; if (a_ram_we !== 1'b1 || a_ram_addr !== 16'h0200 || a_ram_be !== 4'hF || a_ram_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bubble_ram got %b/%h/%h/%h want 1/0200/f/deadbeef", a_ram_we, a_ram_addr, a_ram_be, a_ram_wdata); end
    vectors++; if (a_ins_rvalid !== 1'b1) begin miscompares++; $display("FAIL bubble_beat0_rvalid got %b want 1", a_ins_rvalid); end
    tick();
    ins_req = 1'b1; ins_addr = 16'h0401;
    data_we = 1'b0; data_addr = 16'h0208; data_be = 4'h0; data_wdata = '0;
    #1;
    vectors++; if (a_ins_rvalid !== 1'b0 || a_data_rvalid !== 1'b0) begin miscompares++; $display("FAIL bubble_store_norv got ins=%b data=%b want 0/0", a_ins_rvalid, a_data_rvalid); end
    vectors++; if (a_ins_gnt !== 1'b1 || a_data_gnt !== 1'b0) begin miscompares++; $display("FAIL bubble_still_burst got ins=%b data=%b want 1/0", a_ins_gnt, a_data_gnt); end
    tick();
    ins_addr = 16'h0402; ins_last = 1'b1;
    #1;
    vectors++; if (a_ins_gnt !== 1'b1) begin miscompares++; $display("FAIL bubble_last got %b want 1", a_ins_gnt); end
    tick();
    ins_req = 1'b0; ins_last = 1'b0;
    #1;
    vectors++; if (a_data_gnt !== 1'b1) begin miscompares++; $display("FAIL bubble_after_load got %b want 1", a_data_gnt); end
    quiet(4);
  endtask

  // ReadLatency=3 instance: load on even cycles, single-beat refill on odd cycles.
  task automatic test_latency;
    logic exp_irv, exp_drv;
    for (int k = 0; k < 12; k++) begin
      data_req = (k < 8) && (k % 2 == 0); data_we = 1'b0; data_addr = 16'h0500 + 16'(k);
      ins_req = (k < 8) && (k % 2 == 1); ins_last = 1'b1; ins_addr = 16'h0600 + 16'(k);
      exp_irv = (k >= 3) && (k < 11) && ((k - 3) % 2 == 1);
      exp_drv = (k >= 3) && (k < 11) && ((k - 3) % 2 == 0);
      #1;
      vectors++; if (b_data_gnt !== data_req || b_ins_gnt !== ins_req) begin miscompares++; $display("FAIL lat3_gnt k=%0d got data=%b ins=%b want %b/%b", k, b_data_gnt, b_ins_gnt, data_req, ins_req); end
      vectors++; if (b_ins_rvalid !== exp_irv || b_data_rvalid !== exp_drv) begin miscompares++; $display("FAIL lat3_rvalid k=%0d got ins=%b data=%b want %b/%b", k, b_ins_rvalid, b_data_rvalid, exp_irv, exp_drv); end
      tick();
    end
    quiet(2);
  endtask

  task automatic test_reset_mid_burst;
    for (int b = 0; b <= 10; b++) begin
      ins_req = 1'b1; ins_last = 1'b0; ins_addr = 16'h0800 + 16'(b);
      #1;
      vectors++; if (a_ins_gnt !== 1'b1) begin miscompares++; $display("FAIL rstmid_beat b=%0d got %b want 1", b, a_ins_gnt); end
      tick();
    end
    ins_addr = 16'h080B;
    #1;
    reset = 1'b1;
    #1;
    vectors++; if ({a_ins_gnt, a_data_gnt, a_ins_rvalid, a_data_rvalid} !== 4'b0) begin miscompares++; $display("FAIL rstmid_ctrl got %b%b%b%b want 0000", a_ins_gnt, a_data_gnt, a_ins_rvalid, a_data_rvalid); end
    vectors++; if ({a_ram_addr, a_ram_we, a_ram_be, a_ram_wdata, a_rdata} !== '0) begin miscompares++; $display("FAIL rstmid_ram got %h/%b/%h/%h/%h want 0", a_ram_addr, a_ram_we, a_ram_be, a_ram_wdata, a_rdata); end
    vectors++; if (b_ins_rvalid !== 1'b0 || b_data_rvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_lat3 got %b/%b want 0/0", b_ins_rvalid, b_data_rvalid); end
    quiet(0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if ({a_ins_rvalid, a_data_rvalid, b_ins_rvalid, b_data_rvalid} !== 4'b0) begin miscompares++; $display("FAIL rstmid_norv i=%0d got %b%b%b%b want 0000", i, a_ins_rvalid, a_data_rvalid, b_ins_rvalid, b_data_rvalid); end
    end
    ins_req = 1'b1; ins_last = 1'b0; ins_addr = 16'h0000;
    #1;
    vectors++; if (a_ins_gnt !== 1'b1 || a_ram_addr !== 16'h0000) begin miscompares++; $display("FAIL rstmid_newburst got %b/%h want 1/0000", a_ins_gnt, a_ram_addr); end
    tick();
    ins_addr = 16'h0001; data_req = 1'b1; data_addr = 16'h0700;
    #1;
    vectors++; if (a_ins_gnt !== 1'b1 || a_data_gnt !== 1'b0) begin miscompares++; $display("FAIL rstmid_locked got ins=%b data=%b want 1/0", a_ins_gnt, a_data_gnt); end
    tick();
    data_req = 1'b0; ins_addr = 16'h0002; ins_last = 1'b1;
    tick();
    quiet(3);
  endtask

  initial begin
    quiet(0);
    ram_rdata = '0;
    test_reset();
    test_single_beat();
    test_collision();
    test_starvation();
    test_bubble();
    test_latency();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing");
    $fatal(1);
  end

endmodule
